mem_responder: RTL

- Memory-side responder for the core's single-outstanding IO request/response protocol (reqValid/addr in; respValid/rdata out).
- Sits behind the instruction fetch and load/store initiators, or behind an arbiter in front of them.
- Holds a word-organised RAM and answers each accepted request exactly once, after a fixed programmable latency.
- Also accepts byte-masked writes, so the same protocol can load programs and serve stores.

---
 rtl/mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-organised RAM answering single-outstanding requests after a fixed latency.
// Writes are byte-masked and commit on the accept edge. Reads sample the array when the response is loaded.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_reqValid,
   input  logic [31:0] io_addr,
   input  logic        io_wen,
   input  logic [31:0] io_wdata,
   input  logic [3:0]  io_wstrb,
   output logic        io_respValid,
   output logic [31:0] io_rdata,
   output logic        io_respErr,
   output logic        busy
);

   // state | meaning
   // IDLE  | waiting for io_reqValid; accepts on this edge
   // WAIT  | latency counter running down to zero
   // RESP  | one-cycle response; io_reqValid ignored
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          CW       = $clog2(LATENCY + 1);
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
   localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [31:0]     off;
   logic            dec_err;
   logic [AW-1:0]   dec_idx;
   logic [AW-1:0]   idx_q;
   logic            wen_q;
   logic            err_q;
   logic            accept;
   logic            enter_resp;
   logic [AW-1:0]   rd_idx;
   logic            rd_wen;
   logic            rd_err;
   logic [31:0]     mem [DEPTH_WORDS];

   assign off     = io_addr - BASE_ADDR;
   assign dec_err = (io_addr[1:0] != 2'b00) || (off >= SPAN);
   assign dec_idx = off[AW+1:2];

   assign accept     = (state == IDLE) && io_reqValid;
   assign enter_resp = (state_nxt == RESP);

   // With LATENCY=1 the response is loaded on the accept edge itself, so use the live decode
   assign rd_idx = (state == IDLE) ? dec_idx : idx_q;
   assign rd_wen = (state == IDLE) ? io_wen  : wen_q;
   assign rd_err = (state == IDLE) ? dec_err : err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io_reqValid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == '0)   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      io_respValid = (state == RESP);
      busy         = (state != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
         wen_q <= 1'b0;
         err_q <= 1'b0;
      end else if (accept) begin
         idx_q <= dec_idx;
         wen_q <= io_wen;
         err_q <= dec_err;
      end
   end

   always_ff @(posedge clock) begin
      if (accept && io_wen && !dec_err) begin
         for (int b = 0; b < 4; b++) begin
            if (io_wstrb[b]) mem[dec_idx][8*b +: 8] <= io_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_rdata   <= '0;
         io_respErr <= 1'b0;
      end else if (enter_resp) begin
         io_respErr <= rd_err;
         io_rdata   <= (rd_wen || rd_err) ? 32'h0 : mem[rd_idx];
      end
   end

endmodule
